// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between NUM_REQ requesters.
// Optional macro ALU_ARB_LOCK_EN adds req_lock_i so a winner can keep top priority for the next grant.
module alu_arbiter #(
    parameter int  WIDTH   = 32,
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*3-1:0]     req_op_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_lock_i,
`endif
    output logic [2:0]               alu_op_o,
    output logic [WIDTH-1:0]         alu_a_o,
    output logic [WIDTH-1:0]         alu_b_o,
    input  logic [WIDTH-1:0]         alu_result_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [IDW-1:0]           resp_id_o,
    output logic [WIDTH-1:0]         resp_result_o,
    output logic                     busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } issue_t;

    issue_t [NUM_REQ-1:0] req_fields;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_unpack
        assign req_fields[r] = {req_op_i[3*r +: 3], req_a_i[WIDTH*r +: WIDTH], req_b_i[WIDTH*r +: WIDTH]};
    end

    logic [1:0]       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    issue_t           issue_q, issue_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;

    // Rotating priority search starting at rr_ptr_q
    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    int                 sum;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        sum       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum  = int'(rr_ptr_q) + k;
            cand = IDW'((sum >= NUM_REQ) ? sum - NUM_REQ : sum);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    logic [NUM_REQ-1:0] grant_oh;

    always_comb begin
        grant_oh = '0;
        if (grant_vld) grant_oh[grant_idx] = 1'b1;
    end

    assign req_ready_o = (rst_ni && state_q == S_IDLE) ? grant_oh : '0;

    logic [IDW-1:0] next_ptr;

    always_comb begin
        next_ptr = (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
`ifdef ALU_ARB_LOCK_EN
        // A locked winner stays first in line so its op sequence runs back-to-back
        if (req_lock_i[grant_idx]) next_ptr = grant_idx;
`endif
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        issue_d       = issue_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    issue_d  = req_fields[grant_idx];
                    id_d     = grant_idx;
                    rr_ptr_d = next_ptr;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_result_d = alu_result_i;
                resp_id_d     = id_q;
                resp_valid_d  = 1'b1;
                state_d       = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            issue_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            issue_q       <= issue_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign alu_op_o      = issue_q.op;
    assign alu_a_o       = issue_q.a;
    assign alu_b_o       = issue_q.b;
    assign resp_valid_o  = resp_valid_q;
    assign resp_id_o     = resp_id_q;
    assign resp_result_o = resp_result_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: opcode vector table plus hand-written arbitration/backpressure/reset sequences.
module tb_alu_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*3-1:0] req_op;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
`ifdef ALU_ARB_LOCK_EN
    logic [N-1:0]   req_lock;
`endif
    logic [2:0]     alu_op;
    logic [W-1:0]   alu_a, alu_b, alu_res;
    logic           resp_valid, resp_ready;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_result;
    logic           busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
`ifdef ALU_ARB_LOCK_EN
        .req_lock_i(req_lock),
`endif
        .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_result_i(alu_res),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_id_o(resp_id), .resp_result_o(resp_result), .busy_o(busy)
    );

    // External combinational ALU
    always_comb begin
        case (alu_op)
            3'd0:    alu_res = alu_a + alu_b;
            3'd1:    alu_res = alu_a - alu_b;
            3'd2:    alu_res = alu_a << alu_b[4:0];
            3'd3:    alu_res = alu_a >> alu_b[4:0];
            3'd4:    alu_res = W'($signed(alu_a) >>> alu_b[4:0]);
            3'd5:    alu_res = alu_a ^ alu_b;
            3'd6:    alu_res = alu_a | alu_b;
            default: alu_res = alu_a & alu_b;
        endcase
    end

    typedef struct {
        int         r;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*r +: 3] = op;
        req_a[W*r +: W]  = a;
        req_b[W*r +: W]  = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Single request on requester r; starts and ends 1 time unit after an edge in IDLE
    task automatic do_single(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp);
        logic [N-1:0] oh;
        oh = '0;
        oh[r] = 1'b1;
        set_req(r, op, a, b);
        req_valid = oh;
        #1;
        chk("single_ready", 32'(req_ready), 32'(oh));
        step();
        req_valid = '0;
        chk("single_exec_busy", 32'(busy), 32'd1);
        chk("single_exec_nvalid", 32'(resp_valid), 32'd0);
        chk("single_alu_op", 32'(alu_op), 32'(op));
        chk("single_alu_a", alu_a, a);
        step();
        chk("single_resp_valid", 32'(resp_valid), 32'd1);
        chk("single_resp_id", 32'(resp_id), 32'(r));
        chk("single_resp_result", resp_result, exp);
        step();
        chk("single_idle_valid", 32'(resp_valid), 32'd0);
        chk("single_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] oh;
        vecs[0] = '{0, 3'd0, 32'd5,         32'd7,         32'd12};
        vecs[1] = '{1, 3'd1, 32'd3,         32'd5,         32'hFFFF_FFFE};
        vecs[2] = '{2, 3'd2, 32'd1,         32'd31,        32'h8000_0000};
        vecs[3] = '{3, 3'd3, 32'hF000_0000, 32'd4,         32'h0F00_0000};
        vecs[4] = '{0, 3'd4, 32'h8000_0010, 32'd4,         32'hF800_0001};
        vecs[5] = '{1, 3'd5, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5};
        vecs[6] = '{2, 3'd6, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};
        vecs[7] = '{3, 3'd7, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h0000_BEEF};
        vecs[8] = '{1, 3'd0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000};

        rst_n      = 1'b0;
        req_valid  = '1;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
`ifdef ALU_ARB_LOCK_EN
        req_lock   = '0;
`endif

        // Reset with every requester asking
        repeat (2) begin
            step();
            chk("rst_ready", 32'(req_ready), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_resp_result", resp_result, 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;

        // Opcode table
        for (int i = 0; i < 9; i++)
            do_single(vecs[i].r, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // All four valid: grant order 0,1,2,3,0, one response every 3 cycles
        do_reset();
        for (int r = 0; r < N; r++) set_req(r, 3'd1, 32'd10, 32'(r));
        req_valid = '1;
        for (int g = 0; g < 5; g++) begin
            oh = '0;
            oh[g % N] = 1'b1;
            #1;
            chk("rr_ready", 32'(req_ready), 32'(oh));
            step();
            chk("rr_exec_ready", 32'(req_ready), 32'd0);
            step();
            chk("rr_resp_valid", 32'(resp_valid), 32'd1);
            chk("rr_resp_id", 32'(resp_id), 32'(g % N));
            chk("rr_resp_result", resp_result, 32'd10 - 32'(g % N));
            step();
        end
        req_valid = '0;

        // Backpressure: rr_ptr is 1 here, req1 wins over req0
        set_req(1, 3'd4, 32'h8000_0000, 32'd4);
        set_req(0, 3'd0, 32'd3, 32'd4);
        req_valid  = 4'b0011;
        resp_ready = 1'b0;
        #1;
        chk("bp_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0001;
        step();
        chk("bp_resp_valid", 32'(resp_valid), 32'd1);
        chk("bp_resp_result", resp_result, 32'hF800_0000);
        repeat (5) begin
            step();
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_result", resp_result, 32'hF800_0000);
            chk("bp_hold_id", 32'(resp_id), 32'd1);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_next_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        chk("bp_next_id", 32'(resp_id), 32'd0);
        chk("bp_next_result", resp_result, 32'd7);
        step();

        // Wrap: rr_ptr=3 after granting req2, then 1001 -> 3 then 0
        do_reset();
        do_single(2, 3'd0, 32'd1, 32'd1, 32'd2);
        set_req(3, 3'd6, 32'hF0, 32'h0F);
        set_req(0, 3'd7, 32'hFF, 32'h3C);
        req_valid = 4'b1001;
        #1;
        chk("wrap_ready3", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0001;
        step();
        chk("wrap_id3", 32'(resp_id), 32'd3);
        chk("wrap_res3", resp_result, 32'hFF);
        step();
        chk("wrap_ready0", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        step();
        chk("wrap_id0", 32'(resp_id), 32'd0);
        chk("wrap_res0", resp_result, 32'h3C);
        step();

        // Reset while in EXEC drops the op
        set_req(1, 3'd0, 32'd20, 32'd22);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        chk("midrst_exec_busy", 32'(busy), 32'd1);
        do_reset();
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", resp_result, 32'd0);
        repeat (3) begin
            step();
            chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        do_single(2, 3'd5, 32'hF0, 32'hFF, 32'h0F);

`ifdef ALU_ARB_LOCK_EN
        // Locked req1 is granted twice in a row after req0
        do_reset();
        req_lock = 4'b0010;
        set_req(0, 3'd0, 32'd1, 32'd2);
        set_req(1, 3'd1, 32'd9, 32'd4);
        req_valid = 4'b0011;
        for (int g = 0; g < 3; g++) begin
            oh = (g == 0) ? 4'b0001 : 4'b0010;
            #1;
            chk("lock_ready", 32'(req_ready), 32'(oh));
            step();
            step();
            chk("lock_id", 32'(resp_id), (g == 0) ? 32'd0 : 32'd1);
            chk("lock_result", resp_result, (g == 0) ? 32'd3 : 32'd5);
            step();
        end
        req_valid = '0;
        req_lock  = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
